// File: rtl/fabint_pkg.sv
// Shared types and constants for the fabric interrupt scheduler and its helpers.
package fabint_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GAP    = 2'd2
   } state_e;

   localparam int DEF_NUM_SRC     = 4;
   localparam int DEF_ID_W        = 2;
   localparam int DEF_MIN_GAP     = 8;
   localparam int DEF_ACK_TIMEOUT = 1024;

   // Bits needed to hold values 0..value-1; never returns less than 1.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/fabint_scheduler_if.sv
// Event-source / firmware side signals of the scheduler, grouped for port hookup.
interface fabint_scheduler_if #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
);

   logic [NUM_SRC-1:0] src_pulse;
   logic [NUM_SRC-1:0] src_enable;
   logic               irq_ack;
   logic [NUM_SRC-1:0] ovf_clear;
   logic               fab_int;
   logic [ID_W-1:0]    irq_id;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] overflow;
   logic               timeout_err;

   modport master (
      output src_pulse, src_enable, irq_ack, ovf_clear,
      input  fab_int, irq_id, pending, overflow, timeout_err
   );

   modport slave (
      input  src_pulse, src_enable, irq_ack, ovf_clear,
      output fab_int, irq_id, pending, overflow, timeout_err
   );

endinterface

// File: rtl/fabint_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

   // Scan downward so the last hit written is the first one in upward order.
   always_comb begin : pick
      logic [IDX_W:0] sum;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
         if (sum >= N_W) sum = sum - N_W;
         if (req_i[sum[IDX_W-1:0]]) begin
            idx_o = sum[IDX_W-1:0];
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fabint_scheduler.sv
// Shares the single FABINT line between fabric event sources: latch, round-robin
// grant, hold until ack (or timeout), then enforce a quiet gap.
module fabint_scheduler
   import fabint_pkg::*;
#(
   parameter int NUM_SRC     = DEF_NUM_SRC,
   parameter int ID_W        = DEF_ID_W,
   parameter int MIN_GAP     = DEF_MIN_GAP,
   parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
   input logic               clk,
   input logic               rst,
   fabint_scheduler_if.slave bus
);

   localparam int               WAIT_W    = clog2(ACK_TIMEOUT);
   localparam int               GAP_W     = clog2(MIN_GAP);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(MIN_GAP - 1);
   localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_SRC - 1);

   state_e             state_q, state_d;
   logic               fab_int_q, fab_int_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] overflow_q, overflow_d;
   logic               timeout_q, timeout_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [GAP_W-1:0]   gap_q, gap_d;

   logic [NUM_SRC-1:0] event_v;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic               win_any;
   logic               ack_take;
   logic [ID_W-1:0]    ptr_after;

   assign event_v   = bus.src_pulse & bus.src_enable;
   assign eligible  = pending_q & bus.src_enable;
   assign ack_take  = (state_q == ASSERT) && bus.irq_ack;
   assign ack_clr   = ack_take ? (NUM_SRC'(1) << irq_id_q) : '0;
   assign ptr_after = (irq_id_q == LAST_ID) ? '0 : irq_id_q + ID_W'(1);

   // A fresh event beats the ack that clears it, and is not an overflow.
   assign pending_d  = event_v | (pending_q & ~ack_clr);
   assign overflow_d = (event_v & pending_q & ~ack_clr) | (overflow_q & ~bus.ovf_clear);

   rr_pick #(
      .N     (NUM_SRC),
      .IDX_W (ID_W)
   ) u_pick (
      .req_i (eligible),
      .ptr_i (rr_ptr_q),
      .idx_o (winner),
      .any_o (win_any)
   );

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_d   = state_q;
      fab_int_d = fab_int_q;
      irq_id_d  = irq_id_q;
      rr_ptr_d  = rr_ptr_q;
      timeout_d = timeout_q;
      wait_d    = wait_q;
      gap_d     = gap_q;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               irq_id_d  = winner;
               fab_int_d = 1'b1;
               wait_d    = '0;
               state_d   = ASSERT;
            end
         end
         ASSERT: begin
            if (bus.irq_ack || (wait_q == WAIT_LAST)) begin
               fab_int_d = 1'b0;
               rr_ptr_d  = ptr_after;
               gap_d     = GAP_LOAD;
               state_d   = (MIN_GAP == 0) ? IDLE : GAP;
               if (!bus.irq_ack) timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         GAP: begin
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= IDLE;
         fab_int_q  <= 1'b0;
         irq_id_q   <= '0;
         rr_ptr_q   <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         timeout_q  <= 1'b0;
         wait_q     <= '0;
         gap_q      <= '0;
      end else begin
         state_q    <= state_d;
         fab_int_q  <= fab_int_d;
         irq_id_q   <= irq_id_d;
         rr_ptr_q   <= rr_ptr_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         wait_q     <= wait_d;
         gap_q      <= gap_d;
      end
   end

   assign bus.fab_int     = fab_int_q;
   assign bus.irq_id      = irq_id_q;
   assign bus.pending     = pending_q;
   assign bus.overflow    = overflow_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_fabint_scheduler.sv
// Scoreboard bench: a transaction-level model predicts each grant (cycle, id);
// a monitor pops and compares whenever fab_int rises.
module tb_fabint_scheduler;

   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int GAP = 8;
   localparam int TO  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fabint_scheduler_if #(.NUM_SRC(N), .ID_W(IDW)) bus ();

   fabint_scheduler #(
      .NUM_SRC     (N),
      .ID_W        (IDW),
      .MIN_GAP     (GAP),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_run  = 0;
   int n_fail = 0;
   int tb_cycle = 0;
   bit mon_on = 1'b0;
   logic [N-1:0] en_v = '1;

   always @(posedge clk) tb_cycle <= tb_cycle + 1;

   // Reference model: pending/overflow sets plus the current grant, with the
   // earliest cycle a new grant decision is allowed kept as an absolute number.
   typedef struct { int cyc; int id; } grant_t;
   grant_t   exp_q[$];
   bit [N-1:0] m_pend, m_ovf;
   bit       m_terr, m_busy;
   int       m_id, m_hi, m_ptr, m_next_ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, tb_cycle);
      end
   endtask

   task automatic model_step(input logic r, input logic [N-1:0] p, input logic [N-1:0] en,
                             input logic a, input logic [N-1:0] oc);
      bit [N-1:0] old;
      int clr;
      int k;
      k = tb_cycle;
      if (r) begin
         m_pend = '0; m_ovf = '0; m_terr = 0; m_busy = 0;
         m_id = 0; m_hi = 0; m_ptr = 0; m_next_ok = k + 1;
         return;
      end
      old = m_pend;
      clr = -1;
      if (m_busy) begin
         if (a || m_hi == TO) begin
            if (a) clr = m_id;
            else   m_terr = 1;
            m_busy    = 0;
            m_ptr     = (m_id + 1) % N;
            m_next_ok = k + 1 + GAP;
         end else begin
            m_hi++;
         end
      end else if (k >= m_next_ok) begin
         for (int s = 0; s < N; s++) begin
            int c;
            c = (m_ptr + s) % N;
            if (old[c] && en[c]) begin
               m_busy = 1; m_id = c; m_hi = 1;
               exp_q.push_back('{k + 1, c});
               break;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         bit ev;
         ev = p[i] & en[i];
         if (ev && old[i] && i != clr) m_ovf[i] = 1;
         else if (oc[i])               m_ovf[i] = 0;
         m_pend[i] = ev | (old[i] && i != clr);
      end
   endtask

   task automatic drive_cycle(input logic r, input logic [N-1:0] p, input logic [N-1:0] en,
                              input logic a, input logic [N-1:0] oc);
      rst            = r;
      bus.src_pulse  = p;
      bus.src_enable = en;
      bus.irq_ack    = a;
      bus.ovf_clear  = oc;
      model_step(r, p, en, a, oc);
      @(negedge clk);
      check("pending", bus.pending, m_pend);
      check("overflow", bus.overflow, m_ovf);
      check("timeout_err", bus.timeout_err, m_terr);
      check("fab_int", bus.fab_int, m_busy);
      if (m_busy) check("irq_id", bus.irq_id, m_id);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, en_v, 1'b0, '0);
   endtask

   // Firmware-like traffic: random pulses, acks while fab_int is high, stray acks.
   task automatic fw(input int cycles, input int ack_pct, input int pulse_pct, input int rst_pm);
      for (int i = 0; i < cycles; i++) begin
         logic [N-1:0] p, oc;
         logic a, r;
         for (int s = 0; s < N; s++) begin
            p[s]  = ($urandom_range(99) < pulse_pct);
            oc[s] = ($urandom_range(99) < 5);
         end
         a = (bus.fab_int && ($urandom_range(99) < ack_pct)) || ($urandom_range(99) < 2);
         r = ($urandom_range(999) < rst_pm);
         drive_cycle(r, p, en_v, a, oc);
      end
   endtask

   // Monitor: each fab_int rise must match the oldest predicted grant.
   initial begin : monitor
      bit prev;
      grant_t g;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (bus.fab_int === 1'b1 && !prev) begin
               check("grant_expected", exp_q.size() > 0, 1'b1);
               if (exp_q.size() > 0) begin
                  g = exp_q.pop_front();
                  check("grant_cycle", tb_cycle, g.cyc);
                  check("grant_id", bus.irq_id, g.id);
               end
            end
            prev = (bus.fab_int === 1'b1);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t, hi;
      rst = 1'b1;
      bus.src_pulse = '0; bus.src_enable = '1; bus.irq_ack = 1'b0; bus.ovf_clear = '0;
      @(negedge clk);
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      mon_on = 1'b1;
      check("rst_irq_id", bus.irq_id, 0);

      // 1: two-cycle latency, ack drops fab_int next cycle
      idle(2);
      drive_cycle(1'b0, 4'b0100, en_v, 1'b0, '0);
      idle(1);
      check("t1_rise", bus.fab_int, 1'b1);
      check("t1_id", bus.irq_id, 2);
      idle(2);
      drive_cycle(1'b0, '0, en_v, 1'b1, '0);
      check("t1_fall", bus.fab_int, 1'b0);
      check("t1_pend2", bus.pending[2], 1'b0);
      idle(GAP + 2);

      // 2: simultaneous pulses, immediate acks, order 0,1,3 from ptr 0
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b1011, en_v, 1'b0, '0);
      fw(60, 100, 0, 0);

      // 3: overflow on repeat pulse, clear, single service
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b0010, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b0010, en_v, 1'b0, '0);
      check("t3_ovf_set", bus.overflow[1], 1'b1);
      drive_cycle(1'b0, '0, en_v, 1'b0, 4'b0010);
      check("t3_ovf_clr", bus.overflow[1], 1'b0);
      fw(30, 100, 0, 0);

      // 4: timeout after TO high cycles, other source served before retry
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b1010, en_v, 1'b0, '0);
      for (t = 0; t < 10 && bus.fab_int !== 1'b1; t++) idle(1);
      check("t4_rise", bus.fab_int, 1'b1);
      hi = 0;
      for (t = 0; t < 100 && bus.fab_int === 1'b1; t++) begin
         hi++;
         idle(1);
      end
      check("t4_high_cycles", hi, TO);
      check("t4_terr", bus.timeout_err, 1'b1);
      check("t4_pend_kept", bus.pending[1], 1'b1);
      for (t = 0; t < GAP + 10 && bus.fab_int !== 1'b1; t++) idle(1);
      check("t4_next_id", bus.irq_id, 3);
      fw(80, 100, 0, 0);

      // 5: disabled source dropped; pulse coinciding with its own ack re-pends
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b0001, 4'b1110, 1'b0, '0);
      check("t5_dropped", bus.pending, 0);
      drive_cycle(1'b0, '0, 4'b1110, 1'b0, '0);
      drive_cycle(1'b0, 4'b0100, en_v, 1'b0, '0);
      idle(1);
      check("t5_id", bus.irq_id, 2);
      drive_cycle(1'b0, 4'b0100, en_v, 1'b1, '0);
      check("t5_repend", bus.pending[2], 1'b1);
      check("t5_ovf", bus.overflow[2], 1'b0);
      fw(30, 100, 0, 0);

      // 6: reset mid-ASSERT and mid-GAP, then normal latency
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b0, 4'b0001, en_v, 1'b0, '0);
      idle(1);
      check("t6_assert", bus.fab_int, 1'b1);
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      check("t6_rst_outs", {bus.fab_int, bus.irq_id, bus.pending, bus.overflow, bus.timeout_err}, 0);
      drive_cycle(1'b0, 4'b1000, en_v, 1'b0, '0);
      idle(1);
      check("t6_lat_a", {bus.fab_int, bus.irq_id}, {1'b1, 2'd3});
      drive_cycle(1'b0, '0, en_v, 1'b1, '0);
      idle(1);
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      check("t6_rst_gap", {bus.fab_int, bus.pending}, 0);
      drive_cycle(1'b0, 4'b0100, en_v, 1'b0, '0);
      idle(1);
      check("t6_lat_b", {bus.fab_int, bus.irq_id}, {1'b1, 2'd2});
      fw(20, 100, 0, 0);

      // Random traffic with changing enables and occasional reset
      for (int blk = 0; blk < 40; blk++) begin
         en_v = N'($urandom | $urandom);
         fw(50, 25, 8, 3);
      end
      en_v = '1;
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      drive_cycle(1'b1, '0, en_v, 1'b0, '0);
      #1;
      check("grants_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
